// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Control sequencer for a simple fetch/execute datapath. Walks the PC
//   through MAR, waits for memory, loads IR, hands off to the execute stage
//   and services PC redirects. All datapath controls are Moore outputs
//   decoded from the state register.
//
// Parameters
//   MEM_TIMEOUT   maximum FETCH_MEM wait cycles before abort (1..255)
//
// Build option
//   FETCH_PAUSE_EN  when defined, a PAUSE state follows each completed
//                   instruction (Run=1) and is left on Continue=1.
//
// Ports
//   Clk           sole clock, rising edge
//   Reset         asynchronous active-low reset
//   Run           level, permits instruction fetch
//   Continue      level, leaves PAUSE (FETCH_PAUSE_EN builds only)
//   Mem_Ready     memory read data valid
//   Exec_Done     execute stage finished without PC change
//   Redirect_Req  execute stage requests PC load
//   Redirect_Src  redirect source: 0 address adder, 1 bus
//   LD_PC         PC load enable
//   Sel_PC        PC mux: 00 incr, 01 adder, 10 bus, 11 hold
//   GatePC        drive PC onto bus
//   LD_MAR        MAR load enable
//   Mem_OE        memory read enable
//   LD_MDR        MDR load enable
//   LD_IR         IR load enable
//   Exec_Start    one-cycle pulse starting execute
//   Redirect_Ack  one-cycle pulse accepting redirect
//   Mem_Err       sticky fetch-timeout flag (cleared by reset only)
//   Fetch_Count   number of IR loads, wraps at 16 bits
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic        Mem_Ready,
    input  logic        Exec_Done,
    input  logic        Redirect_Req,
    input  logic        Redirect_Src,
    output logic        LD_PC,
    output logic [1:0]  Sel_PC,
    output logic        GatePC,
    output logic        LD_MAR,
    output logic        Mem_OE,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        Exec_Start,
    output logic        Redirect_Ack,
    output logic        Mem_Err,
    output logic [15:0] Fetch_Count
);

    typedef enum logic [2:0] {
        S_HALTED    = 3'd0,
        S_FETCH_MAR = 3'd1,
        S_FETCH_MEM = 3'd2,
        S_FETCH_IR  = 3'd3,
        S_EXEC      = 3'd4,
        S_REDIRECT  = 3'd5
`ifdef FETCH_PAUSE_EN
        , S_PAUSE   = 3'd6
`endif
    } state_e;

    // Counter value seen on the last permitted wait cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        exec_first_q, exec_first_d;

`ifndef FETCH_PAUSE_EN
    logic        unused_continue_s;
    assign unused_continue_s = Continue;
`endif

    // Where to go once an instruction has finished (Exec_Done or redirect).
    function automatic state_e after_instr(input logic run);
        state_e nxt;
        if (run) begin
`ifdef FETCH_PAUSE_EN
            nxt = S_PAUSE;
`else
            nxt = S_FETCH_MAR;
`endif
        end else begin
            nxt = S_HALTED;
        end
        return nxt;
    endfunction

    // State and datapath-counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_HALTED;
            wait_cnt_q    <= 8'd0;
            mem_err_q     <= 1'b0;
            fetch_count_q <= 16'h0000;
            exec_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            fetch_count_q <= fetch_count_d;
            exec_first_q  <= exec_first_d;
        end
    end

    // Next-state, wait counter, error flag and fetch counter.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        fetch_count_d = fetch_count_q;
        exec_first_d  = 1'b0;
        case (state_q)
            S_HALTED: begin
                // A latched timeout pins the sequencer here until reset.
                if (Run && !mem_err_q) begin
                    state_d = S_FETCH_MAR;
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_FETCH_MAR: begin
                state_d    = S_FETCH_MEM;
                wait_cnt_d = 8'd0;
            end
            S_FETCH_MEM: begin
                // Data arriving on the last wait cycle still wins.
                if (Mem_Ready) begin
                    state_d = S_FETCH_IR;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = S_HALTED;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_FETCH_IR: begin
                fetch_count_d = fetch_count_q + 16'd1;
                exec_first_d  = 1'b1;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                if (Redirect_Req) begin
                    state_d = S_REDIRECT;
                end else if (Exec_Done) begin
                    state_d = after_instr(Run);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_REDIRECT: begin
                state_d = after_instr(Run);
            end
`ifdef FETCH_PAUSE_EN
            S_PAUSE: begin
                if (!Run) begin
                    state_d = S_HALTED;
                end else if (Continue) begin
                    state_d = S_FETCH_MAR;
                end else begin
                    state_d = S_PAUSE;
                end
            end
`endif
            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        LD_PC        = 1'b0;
        Sel_PC       = 2'b11;
        GatePC       = 1'b0;
        LD_MAR       = 1'b0;
        Mem_OE       = 1'b0;
        LD_MDR       = 1'b0;
        LD_IR        = 1'b0;
        Exec_Start   = 1'b0;
        Redirect_Ack = 1'b0;
        case (state_q)
            S_FETCH_MAR: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                Sel_PC = 2'b00;
            end
            S_FETCH_MEM: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
            end
            S_FETCH_IR: begin
                LD_IR = 1'b1;
            end
            S_EXEC: begin
                Exec_Start = exec_first_q;
            end
            S_REDIRECT: begin
                LD_PC        = 1'b1;
                Sel_PC       = Redirect_Src ? 2'b10 : 2'b01;
                Redirect_Ack = 1'b1;
            end
            default: begin
                LD_PC = 1'b0;
            end
        endcase
    end

    assign Mem_Err     = mem_err_q;
    assign Fetch_Count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed self-checking bench for fetch_sequencer (MEM_TIMEOUT = 15).
//   Inputs change 1 time unit after the rising edge, outputs are sampled
//   there as well; a negedge monitor tallies control pulses.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Run;
    logic        Continue;
    logic        Mem_Ready;
    logic        Exec_Done;
    logic        Redirect_Req;
    logic        Redirect_Src;
    logic        LD_PC;
    logic [1:0]  Sel_PC;
    logic        GatePC;
    logic        LD_MAR;
    logic        Mem_OE;
    logic        LD_MDR;
    logic        LD_IR;
    logic        Exec_Start;
    logic        Redirect_Ack;
    logic        Mem_Err;
    logic [15:0] Fetch_Count;

    int checks   = 0;
    int failures = 0;
    int n_inc    = 0;
    int n_ir     = 0;
    int n_start  = 0;
    int base_inc;
    int base_ir;
    int base_start;

    fetch_sequencer #(.MEM_TIMEOUT(15)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .Continue     (Continue),
        .Mem_Ready    (Mem_Ready),
        .Exec_Done    (Exec_Done),
        .Redirect_Req (Redirect_Req),
        .Redirect_Src (Redirect_Src),
        .LD_PC        (LD_PC),
        .Sel_PC       (Sel_PC),
        .GatePC       (GatePC),
        .LD_MAR       (LD_MAR),
        .Mem_OE       (Mem_OE),
        .LD_MDR       (LD_MDR),
        .LD_IR        (LD_IR),
        .Exec_Start   (Exec_Start),
        .Redirect_Ack (Redirect_Ack),
        .Mem_Err      (Mem_Err),
        .Fetch_Count  (Fetch_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse tally sampled mid-cycle.
    always @(negedge Clk) begin
        if (LD_PC && (Sel_PC == 2'b00)) n_inc++;
        if (LD_IR) n_ir++;
        if (Exec_Start) n_start++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    // Advance until Exec_Start is seen, bounded to 20 cycles.
    task automatic wait_start(input string tag);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (Exec_Start) break;
        end
        check_eq(tag, 32'(Exec_Start), 32'd1);
    endtask

    // In pause builds, step through the one PAUSE cycle (Continue held 1).
    task automatic pass_pause();
`ifdef FETCH_PAUSE_EN
        check_eq("pause_quiet", 32'({LD_PC, GatePC, LD_MAR, Mem_OE, LD_MDR, LD_IR, Sel_PC}), 32'h3);
        cycle();
`endif
    endtask

    task automatic reset_pulse();
        Reset = 1'b0;
        cycle();
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; Mem_Ready = 1'b0; Exec_Done = 1'b0;
        Redirect_Req = 1'b0; Redirect_Src = 1'b0;
`ifdef FETCH_PAUSE_EN
        Continue = 1'b1;
`else
        Continue = 1'b0;
`endif
        repeat (3) cycle();

        // Reset state
        check_eq("rst_sel_pc", 32'(Sel_PC), 32'd3);
        check_eq("rst_enables", 32'({LD_PC, GatePC, LD_MAR, Mem_OE, LD_MDR, LD_IR, Exec_Start, Redirect_Ack}), 32'd0);
        check_eq("rst_mem_err", 32'(Mem_Err), 32'd0);
        check_eq("rst_count", 32'(Fetch_Count), 32'd0);

        // First instruction, cycle by cycle (4-cycle latency to Exec_Start)
        base_inc = n_inc; base_ir = n_ir; base_start = n_start;
        Reset = 1'b1; Run = 1'b1; Mem_Ready = 1'b1;
        cycle();
        check_eq("mar_ctl", 32'({GatePC, LD_MAR, LD_PC, Sel_PC}), 32'b11100);
        cycle();
        check_eq("mem_ctl", 32'({Mem_OE, LD_MDR, LD_PC, Sel_PC}), 32'b11011);
        cycle();
        check_eq("ir_ld", 32'(LD_IR), 32'd1);
        check_eq("ir_count_before", 32'(Fetch_Count), 32'd0);
        cycle();
        check_eq("latency_exec_start", 32'(Exec_Start), 32'd1);
        check_eq("count_after_ir", 32'(Fetch_Count), 32'd1);
        cycle();
        check_eq("exec_start_once", 32'(Exec_Start), 32'd0);
        Exec_Done = 1'b1;
        cycle();
        Exec_Done = 1'b0;
        pass_pause();
        check_eq("refetch_mar", 32'({LD_MAR, Sel_PC}), 32'b100);

        // Two more instructions; halt after the third
        for (int k = 2; k <= 3; k++) begin
            wait_start("instr_start");
            cycle();
            cycle();
            if (k == 3) Run = 1'b0;
            Exec_Done = 1'b1;
            cycle();
            Exec_Done = 1'b0;
            if (k == 2) pass_pause();
        end
        check_eq("three_count", 32'(Fetch_Count), 32'd3);
        check_eq("three_inc_loads", 32'(n_inc - base_inc), 32'd3);
        check_eq("three_ir_loads", 32'(n_ir - base_ir), 32'd3);
        check_eq("three_starts", 32'(n_start - base_start), 32'd3);
        check_eq("halted_after_run0", 32'({Sel_PC, LD_MAR}), 32'b110);

        // Redirect wins over Exec_Done, bus source
        Run = 1'b1;
        wait_start("redir_start");
        Redirect_Req = 1'b1; Exec_Done = 1'b1; Redirect_Src = 1'b1;
        cycle();
        Redirect_Req = 1'b0; Exec_Done = 1'b0;
        check_eq("redir_bus", 32'({LD_PC, Sel_PC, Redirect_Ack}), 32'b1101);
        cycle();
        pass_pause();
        check_eq("redir_ack_pulse", 32'({Redirect_Ack, LD_MAR, Sel_PC}), 32'b0100);

        // Redirect from adder, Run dropped -> halt afterwards
        wait_start("redir2_start");
        Redirect_Req = 1'b1; Redirect_Src = 1'b0;
        cycle();
        Redirect_Req = 1'b0; Run = 1'b0;
        check_eq("redir_adder", 32'({LD_PC, Sel_PC, Redirect_Ack}), 32'b1011);
        cycle();
        check_eq("redir_then_halt", 32'({LD_PC, GatePC, Sel_PC}), 32'b0011);
        check_eq("redir_count", 32'(Fetch_Count), 32'd5);

        // Run dropped mid-fetch still completes the instruction
        Run = 1'b1;
        cycle();
        Run = 1'b0;
        wait_start("run_drop_start");
        Exec_Done = 1'b1;
        cycle();
        Exec_Done = 1'b0;
        check_eq("run_drop_count", 32'(Fetch_Count), 32'd6);
        cycle();
        check_eq("run_drop_halted", 32'({GatePC, Sel_PC}), 32'b011);

        // Reset during FETCH_MEM: immediate, no IR load
        Mem_Ready = 1'b0; Run = 1'b1;
        cycle();
        cycle();
        check_eq("in_fetch_mem", 32'(Mem_OE), 32'd1);
        base_ir = n_ir;
        #2;
        Reset = 1'b0;
        #1;
        check_eq("async_rst_outs", 32'({Mem_OE, LD_MDR, LD_PC, Sel_PC}), 32'b00011);
        check_eq("async_rst_count", 32'(Fetch_Count), 32'd0);
        Mem_Ready = 1'b1;
        cycle();
        cycle();
        check_eq("rst_no_ir", 32'(n_ir - base_ir), 32'd0);

        // Fetch counter wrap from 0xFFFF
        Run = 1'b0;
        force dut.fetch_count_q = 16'hFFFF;
        #1;
        release dut.fetch_count_q;
        Reset = 1'b1;
        cycle();
        check_eq("preset_ffff", 32'(Fetch_Count), 32'hFFFF);
        Run = 1'b1;
        wait_start("wrap_start");
        Run = 1'b0; Exec_Done = 1'b1;
        cycle();
        Exec_Done = 1'b0;
        check_eq("wrap_to_zero", 32'(Fetch_Count), 32'd0);

        // Mem_Ready on the final permitted wait cycle beats the timeout
        reset_pulse();
        Mem_Ready = 1'b0; Run = 1'b1;
        cycle();
        cycle();
        repeat (14) cycle();
        Mem_Ready = 1'b1;
        cycle();
        check_eq("ready_wins_ir", 32'(LD_IR), 32'd1);
        check_eq("ready_wins_err", 32'(Mem_Err), 32'd0);
        Run = 1'b0;
        wait_start("ready_wins_start");
        Exec_Done = 1'b1;
        cycle();
        Exec_Done = 1'b0;

        // Timeout after 15 FETCH_MEM cycles, sticky until reset
        Mem_Ready = 1'b0; Run = 1'b1;
        cycle();
        cycle();
        repeat (14) cycle();
        check_eq("t15_still_mem", 32'({Mem_OE, Mem_Err}), 32'b10);
        cycle();
        check_eq("timeout_err", 32'(Mem_Err), 32'd1);
        check_eq("timeout_halt", 32'({Mem_OE, Sel_PC}), 32'b011);
        Mem_Ready = 1'b1;
        repeat (3) cycle();
        check_eq("err_stays_halted", 32'({GatePC, LD_MAR, LD_PC, Mem_Err}), 32'b0001);
        reset_pulse();
        check_eq("err_cleared", 32'(Mem_Err), 32'd0);
        Run = 1'b0;

`ifdef FETCH_PAUSE_EN
        // PAUSE holds until Continue
        Run = 1'b1; Continue = 1'b0;
        wait_start("pause_start");
        Exec_Done = 1'b1;
        cycle();
        Exec_Done = 1'b0;
        repeat (5) cycle();
        check_eq("pause_hold", 32'({LD_PC, GatePC, LD_MAR, Mem_OE, LD_MDR, LD_IR, Sel_PC}), 32'h3);
        Continue = 1'b1;
        cycle();
        check_eq("pause_continue", 32'({LD_MAR, Sel_PC}), 32'b100);
        Run = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum FETCH_MEM wait cycles before abort; legal range 1..255.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Run  input  1  level; high permits instruction fetch.
REQ-005 Continue  input  1  level; leaves PAUSE (FETCH_PAUSE_EN builds only; ignored otherwise).
REQ-006 Mem_Ready  input  1  memory read data valid.
REQ-007 Exec_Done  input  1  execute stage finished, no PC change.
REQ-008 Redirect_Req  input  1  execute stage requests PC load.
REQ-009 Redirect_Src  input  1  0 = address-adder input, 1 = bus input.
REQ-010 LD_PC  output  1  PC register load enable.
REQ-011 Sel_PC  output  2  PC mux select: 00 increment, 01 address adder, 10 bus, 11 hold.
REQ-012 GatePC  output  1  drive PC onto bus.
REQ-013 LD_MAR  output  1  MAR load enable.
REQ-014 Mem_OE  output  1  memory read enable.
REQ-015 LD_MDR  output  1  MDR load enable.
REQ-016 LD_IR  output  1  IR load enable.
REQ-017 Exec_Start  output  1  one-cycle pulse starting execute.
REQ-018 Redirect_Ack  output  1  one-cycle pulse accepting redirect.
REQ-019 Mem_Err  output  1  sticky fetch-timeout flag.
REQ-020 Fetch_Count  output  16  number of IR loads.

Function
REQ-021 States SHALL be HALTED, FETCH_MAR, FETCH_MEM, FETCH_IR, EXEC, REDIRECT, plus PAUSE when FETCH_PAUSE_EN is defined.
REQ-022 All outputs SHALL be Moore, decoded from state only; undriven enables are 0 and Sel_PC is 11.
REQ-023 HALTED: go to FETCH_MAR when Run=1 and Mem_Err=0.
REQ-024 FETCH_MAR (1 cycle): GatePC=1, LD_MAR=1, LD_PC=1, Sel_PC=00; go to FETCH_MEM.
REQ-025 FETCH_MEM: Mem_OE=1, LD_MDR=1; go to FETCH_IR on the first cycle Mem_Ready=1; 8-bit wait counter cleared on entry, incremented each cycle Mem_Ready=0.
REQ-026 Counter reaching MEM_TIMEOUT with Mem_Ready=0 SHALL set Mem_Err and go to HALTED; Mem_Ready in that same cycle wins over timeout.
REQ-027 FETCH_IR (1 cycle): LD_IR=1; Fetch_Count increments, wrapping 0xFFFF to 0x0000; go to EXEC.
REQ-028 EXEC: Exec_Start=1 on the first EXEC cycle only; wait for Exec_Done or Redirect_Req.
REQ-029 Redirect_Req=1 in EXEC SHALL go to REDIRECT regardless of Exec_Done (redirect wins a simultaneous assertion).
REQ-030 Exec_Done=1 alone in EXEC: Run=1 goes to FETCH_MAR (or PAUSE when built), Run=0 goes to HALTED.
REQ-031 REDIRECT (1 cycle): LD_PC=1, Sel_PC=01 if Redirect_Src=0 else 10, Redirect_Ack=1; next state chosen as in REQ-030.
REQ-032 Run deassertion mid-fetch SHALL NOT abort; the instruction completes and the sequencer then halts.
REQ-033 Fetch-to-Exec_Start latency with Mem_Ready already high SHALL be 4 cycles from HALTED (HALTED, FETCH_MAR, FETCH_MEM, FETCH_IR, then EXEC).
REQ-034 Mem_Err clears only on reset; while set, HALTED is never left.

Reset
REQ-035 Reset low SHALL immediately force state HALTED, Mem_Err=0, Fetch_Count=0x0000, wait counter=0, all enables and pulses 0, and Sel_PC=11, regardless of Clk.
REQ-036 Reset asserted mid-fetch or mid-redirect SHALL abandon the operation with no further LD_PC or LD_IR pulse; operation resumes on the first rising edge after release.

Configuration
REQ-037 Macro FETCH_PAUSE_EN defined: after each Exec_Done or REDIRECT with Run=1, the sequencer enters PAUSE, holds all enables at 0, and goes to FETCH_MAR when Continue=1; Run=0 in PAUSE goes to HALTED.
REQ-038 Macro FETCH_PAUSE_EN undefined: PAUSE state is absent, Continue is unused, and REQ-030 applies directly.

Verification
REQ-039 Reset release, Run=1, Mem_Ready=1, Exec_Done pulsed 2 cycles after Exec_Start -> LD_PC with Sel_PC=00 once per instruction; Fetch_Count=3 after three instructions.
REQ-040 Mem_Ready held 0, MEM_TIMEOUT=15 -> Mem_Err=1 after 15 FETCH_MEM cycles; state HALTED; Run=1 does not restart it until Reset.
REQ-041 Redirect_Req and Exec_Done both asserted with Redirect_Src=1 -> one cycle with LD_PC=1, Sel_PC=10, Redirect_Ack=1; no Sel_PC=00 load in that cycle.
REQ-042 Fetch_Count preset to 0xFFFF via 65535 fetches (or forced) plus one fetch -> 0x0000.
REQ-043 Reset pulsed low during FETCH_MEM -> outputs at reset values immediately; no LD_IR; Fetch_Count=0.
REQ-044 FETCH_PAUSE_EN build, Continue=0 after Exec_Done -> all enables 0 indefinitely; Continue=1 -> FETCH_MAR next cycle.
